branch_predictor: RTL and testbench

//  Dynamic predictor for RV32I conditional branches: 2-bit counter table (BHT) + direct-mapped BTB.
//  IF side: combinational lookup on if_pc gives predicted direction/target.
//  EX side: consumes the branch comparator result (ex_br_en), trains tables, flags mispredict, gives redirect PC.

---
 rtl/branch_predictor_if.sv | 56 +++++
 rtl/branch_predictor.sv | 149 ++++++++++++++
 tb/tb_branch_predictor.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Fetch/execute-side bundle for the branch predictor.
// The pipeline is the master; the predictor is the slave.
interface branch_predictor_if #(
  parameter int IDX_BITS = 6
);
  logic [31:0]         if_pc;
  logic                pred_taken;
  logic [31:0]         pred_target;
  logic [IDX_BITS-1:0] pred_idx;

  logic                ex_valid;
  logic [31:0]         ex_pc;
  logic [IDX_BITS-1:0] ex_idx;
  logic                ex_br_en;
  logic [31:0]         ex_target;
  logic                ex_pred_taken;
  logic [31:0]         ex_pred_target;

  logic                mispredict;
  logic [31:0]         redirect_pc;
  logic                ready;

  modport master (
    output if_pc,
    output ex_valid,
    output ex_pc,
    output ex_idx,
    output ex_br_en,
    output ex_target,
    output ex_pred_taken,
    output ex_pred_target,
    input  pred_taken,
    input  pred_target,
    input  pred_idx,
    input  mispredict,
    input  redirect_pc,
    input  ready
  );

  modport slave (
    input  if_pc,
    input  ex_valid,
    input  ex_pc,
    input  ex_idx,
    input  ex_br_en,
    input  ex_target,
    input  ex_pred_taken,
    input  ex_pred_target,
    output pred_taken,
    output pred_target,
    output pred_idx,
    output mispredict,
    output redirect_pc,
    output ready
  );
endinterface

// File: rtl/branch_predictor.sv
// 2-bit counter BHT + direct-mapped BTB, swept clean after reset.
// Define BRANCH_PREDICTOR_GSHARE_EN to XOR global history into the BHT index.
module branch_predictor #(
  parameter int IDX_BITS = 6,
  parameter int GHR_BITS = 6
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bp
);
  localparam int ENTRIES  = 2**IDX_BITS;
  localparam int TAG_BITS = 30 - IDX_BITS;

  if (GHR_BITS < 1 || GHR_BITS > IDX_BITS) begin : g_bad_cfg
    $error("GHR_BITS must be in 1..IDX_BITS");
  end

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_BITS-1:0] r_ptr;
  logic [IDX_BITS-1:0] w_ptr_nxt;

  logic [1:0]          r_bht     [ENTRIES];
  logic                r_btb_v   [ENTRIES];
  logic [TAG_BITS-1:0] r_btb_tag [ENTRIES];
  logic [31:0]         r_btb_tgt [ENTRIES];

  logic                w_ready;
  logic                w_train;
  logic [IDX_BITS-1:0] w_if_idx;
  logic [TAG_BITS-1:0] w_if_tag;
  logic [IDX_BITS-1:0] w_pred_idx;
  logic                w_btb_hit;
  logic [IDX_BITS-1:0] w_ex_btb_idx;
  logic [TAG_BITS-1:0] w_ex_tag;
  logic [1:0]          w_ctr_cur;
  logic [1:0]          w_ctr_nxt;

  assign w_ready = (r_state == S_RUN);
  assign w_train = w_ready & bp.ex_valid;

  // ---------------- sweep FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_INIT;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    unique case (r_state)
      S_INIT: begin
        w_ptr_nxt = r_ptr + IDX_BITS'(1);
        if (r_ptr == '1)
          w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_state_nxt = S_RUN;
      end
      default: begin
        w_state_nxt = S_INIT;
      end
    endcase
  end

  // ---------------- index / history
  assign w_if_idx     = bp.if_pc[IDX_BITS+1:2];
  assign w_if_tag     = bp.if_pc[31:IDX_BITS+2];
  assign w_ex_btb_idx = bp.ex_pc[IDX_BITS+1:2];
  assign w_ex_tag     = bp.ex_pc[31:IDX_BITS+2];

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [GHR_BITS-1:0] r_ghr;

  // History only moves at resolution, so a flush never needs repair.
  always_ff @(posedge clk) begin
    if (rst)
      r_ghr <= '0;
    else if (w_train)
      r_ghr <= GHR_BITS'({r_ghr, bp.ex_br_en});
  end

  assign w_pred_idx = w_if_idx ^ IDX_BITS'(r_ghr);
`else
  assign w_pred_idx = w_if_idx;
`endif

  // ---------------- lookup
  assign w_btb_hit = r_btb_v[w_if_idx]
                   & (r_btb_tag[w_if_idx] == w_if_tag);

  assign bp.pred_idx    = w_pred_idx;
  assign bp.pred_taken  = w_ready
                        & r_bht[w_pred_idx][1]
                        & w_btb_hit;
  assign bp.pred_target = w_btb_hit ? r_btb_tgt[w_if_idx]
                                    : bp.if_pc + 32'd4;
  assign bp.ready       = w_ready;

  // ---------------- counter update
  assign w_ctr_cur = r_bht[bp.ex_idx];

  always_comb begin
    w_ctr_nxt = w_ctr_cur;
    unique case (1'b1)
      bp.ex_br_en & (w_ctr_cur != 2'b11):
        w_ctr_nxt = w_ctr_cur + 2'd1;
      !bp.ex_br_en & (w_ctr_cur != 2'b00):
        w_ctr_nxt = w_ctr_cur - 2'd1;
      default:
        w_ctr_nxt = w_ctr_cur;
    endcase
  end

  // ---------------- table writes
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == S_INIT) begin
        r_bht[r_ptr]   <= 2'b01;
        r_btb_v[r_ptr] <= 1'b0;
      end else if (bp.ex_valid) begin
        r_bht[bp.ex_idx] <= w_ctr_nxt;
        if (bp.ex_br_en) begin
          r_btb_v[w_ex_btb_idx]   <= 1'b1;
          r_btb_tag[w_ex_btb_idx] <= w_ex_tag;
          r_btb_tgt[w_ex_btb_idx] <= bp.ex_target;
        end
      end
    end
  end

  // ---------------- resolution
  assign bp.mispredict  = bp.ex_valid
                        & ((bp.ex_br_en != bp.ex_pred_taken)
                        | (bp.ex_br_en
                        & (bp.ex_pred_target != bp.ex_target)));
  assign bp.redirect_pc = bp.ex_br_en ? bp.ex_target
                                      : bp.ex_pc + 32'd4;
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: expectations are queued at
// drive time and popped when the predictor output is sampled.
`timescale 1ns/1ps
module tb_branch_predictor;
  localparam int IDX_BITS = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  branch_predictor_if #(.IDX_BITS(IDX_BITS)) bus ();

  branch_predictor #(
    .IDX_BITS(IDX_BITS),
    .GHR_BITS(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bp (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] sb_q [$];
  logic [63:0] exp_v;
  logic [63:0] got_v;
  logic [5:0]  m_ghr = '0;
  logic [1:0]  m_ctr;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic        br;
    logic [31:0] tgt;
    logic        pt;
    logic [31:0] ptgt;
    logic        mis;
    logic [31:0] rd;
  } mp_t;

  function automatic logic [5:0] f_idx(input logic [31:0] pc);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    return pc[7:2] ^ m_ghr;
`else
    return pc[7:2];
`endif
  endfunction

  function automatic logic [1:0] f_sat(input logic [1:0] c, input logic t);
    if (t) return (c == 2'b11) ? c : c + 2'd1;
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  // ---------------- stimulus helpers
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.ex_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_ghr = '0;
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (bus.ready !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (bus.ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_ready: ready=%b after %0d cycles, required 1",
               bus.ready, k);
    end
  endtask

  task automatic train(input logic [31:0] pc, input logic br,
                       input logic [31:0] tgt);
    @(negedge clk);
    bus.ex_valid       = 1'b1;
    bus.ex_pc          = pc;
    bus.ex_idx         = f_idx(pc);
    bus.ex_br_en       = br;
    bus.ex_target      = tgt;
    bus.ex_pred_taken  = 1'b0;
    bus.ex_pred_target = pc + 32'd4;
    @(posedge clk);
    #1;
    bus.ex_valid = 1'b0;
    m_ghr = {m_ghr[4:0], br};
  endtask

  task automatic look(input logic [31:0] pc);
    @(negedge clk);
    bus.if_pc = pc;
    #1;
  endtask

  // ---------------- scenarios
  task automatic test_reset();
    bus.if_pc = 32'h60;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_ghr = '0;
    for (int k = 0; k <= 64; k++)
      sb_q.push_back({62'd0, (k == 64), 1'b0});
    for (int k = 0; k <= 64; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      exp_v = sb_q.pop_front();
      got_v = {62'd0, bus.ready, bus.pred_taken};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL reset_seq[%0d]: ready,pred_taken=%b required %b",
                 k, got_v[1:0], exp_v[1:0]);
      end
    end
  endtask

  task automatic test_train();
    train(32'h60, 1'b1, 32'h40);
    m_ctr = 2'b10;
    sb_q.push_back({25'd0, 1'b1, 6'h18, 32'h40});
    look(32'h60);
    exp_v = sb_q.pop_front();
    got_v = {25'd0, bus.pred_taken, bus.pred_idx, bus.pred_target};
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL train: taken/idx/target=%h required %h", got_v, exp_v);
    end
  endtask

  task automatic test_saturation();
    logic [8:0] seq;
    seq = 9'b1_1111_0000;
    for (int i = 8; i >= 0; i--) begin
      train(32'h60, seq[i], 32'h40);
      m_ctr = f_sat(m_ctr, seq[i]);
      sb_q.push_back({31'd0, m_ctr[1], 32'h40});
      look(32'h60);
      exp_v = sb_q.pop_front();
      got_v = {31'd0, bus.pred_taken, bus.pred_target};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL saturation[%0d]: taken/target=%h required %h",
                 8 - i, got_v, exp_v);
      end
    end
  endtask

  task automatic test_hazard();
    logic [1:0] dirs;
    dirs = 2'b01;
    for (int i = 1; i >= 0; i--) begin
      @(negedge clk);
      bus.if_pc          = 32'h60;
      bus.ex_valid       = 1'b1;
      bus.ex_pc          = 32'h60;
      bus.ex_idx         = f_idx(32'h60);
      bus.ex_br_en       = dirs[i];
      bus.ex_target      = 32'h40;
      bus.ex_pred_taken  = m_ctr[1];
      bus.ex_pred_target = 32'h40;
      sb_q.push_back({63'd0, m_ctr[1]});
      m_ctr = f_sat(m_ctr, dirs[i]);
      sb_q.push_back({63'd0, m_ctr[1]});
      #1;
      exp_v = sb_q.pop_front();
      got_v = {63'd0, bus.pred_taken};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL hazard_old[%0d]: pred_taken=%b required %b",
                 i, got_v[0], exp_v[0]);
      end
      @(posedge clk);
      #1;
      bus.ex_valid = 1'b0;
      m_ghr = {m_ghr[4:0], dirs[i]};
      exp_v = sb_q.pop_front();
      got_v = {63'd0, bus.pred_taken};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL hazard_new[%0d]: pred_taken=%b required %b",
                 i, got_v[0], exp_v[0]);
      end
    end
  endtask

  task automatic test_mispredict();
    mp_t tbl [8];
    tbl = '{
      '{1'b1, 32'h200, 1'b1, 32'h80,  1'b0, 32'h204, 1'b1, 32'h80},
      '{1'b1, 32'h100, 1'b0, 32'h180, 1'b1, 32'h180, 1'b1, 32'h104},
      '{1'b1, 32'h100, 1'b1, 32'h180, 1'b1, 32'h180, 1'b0, 32'h180},
      '{1'b1, 32'h100, 1'b1, 32'h180, 1'b1, 32'h184, 1'b1, 32'h180},
      '{1'b1, 32'h100, 1'b0, 32'h180, 1'b0, 32'h104, 1'b0, 32'h104},
      '{1'b0, 32'h200, 1'b1, 32'h80,  1'b0, 32'h204, 1'b0, 32'h80},
      '{1'b1, 32'hFFFFFFFC, 1'b0, 32'h10, 1'b0, 32'h0, 1'b0, 32'h0},
      '{1'b1, 32'h300, 1'b0, 32'h10,  1'b0, 32'h999, 1'b0, 32'h304}
    };
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.ex_valid       = tbl[i].v;
      bus.ex_pc          = tbl[i].pc;
      bus.ex_idx         = f_idx(tbl[i].pc);
      bus.ex_br_en       = tbl[i].br;
      bus.ex_target      = tbl[i].tgt;
      bus.ex_pred_taken  = tbl[i].pt;
      bus.ex_pred_target = tbl[i].ptgt;
      sb_q.push_back({31'd0, tbl[i].mis, tbl[i].rd});
      #1;
      exp_v = sb_q.pop_front();
      got_v = {31'd0, bus.mispredict, bus.redirect_pc};
      bus.ex_valid = 1'b0;
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL mispredict[%0d]: mis/redirect=%h required %h",
                 i, got_v, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        train(32'h400 + 32'(4 * i), 1'b1, 32'h1000 + 32'(16 * i));
        sb_q.push_back({31'd0, 1'b1, 32'h1000 + 32'(16 * i)});
      end else begin
        train(32'h410, 1'b0, 32'h2000);
        sb_q.push_back({31'd0, 1'b0, 32'h414});
      end
    end
    for (int i = 0; i < 5; i++) begin
      look(32'h400 + 32'(4 * i));
      exp_v = sb_q.pop_front();
      got_v = {31'd0, bus.pred_taken, bus.pred_target};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: taken/target=%h required %h",
                 i, got_v, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_init();
    do_reset();
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_ghr = '0;
    for (int k = 0; k <= 64; k++)
      sb_q.push_back({63'd0, (k == 64)});
    for (int k = 0; k <= 64; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      exp_v = sb_q.pop_front();
      got_v = {63'd0, bus.ready};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL reinit_ready[%0d]: ready=%b required %b",
                 k, got_v[0], exp_v[0]);
      end
    end
    sb_q.push_back({31'd0, 1'b0, 32'h64});
    sb_q.push_back({31'd0, 1'b0, 32'h404});
    look(32'h60);
    exp_v = sb_q.pop_front();
    got_v = {31'd0, bus.pred_taken, bus.pred_target};
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL swept_0x60: taken/target=%h required %h", got_v, exp_v);
    end
    look(32'h400);
    exp_v = sb_q.pop_front();
    got_v = {31'd0, bus.pred_taken, bus.pred_target};
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL swept_0x400: taken/target=%h required %h", got_v, exp_v);
    end
    // one taken from the weakly-not-taken init value must flip the prediction
    train(32'h60, 1'b1, 32'h40);
    sb_q.push_back({31'd0, 1'b1, 32'h40});
    look(32'h60);
    exp_v = sb_q.pop_front();
    got_v = {31'd0, bus.pred_taken, bus.pred_target};
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL init_ctr: taken/target=%h required %h", got_v, exp_v);
    end
  endtask

  task automatic test_alias();
    sb_q.push_back({31'd0, 1'b0, 32'h164});
    sb_q.push_back({31'd0, 1'b1, 32'h40});
    look(32'h160);
    exp_v = sb_q.pop_front();
    got_v = {31'd0, bus.pred_taken, bus.pred_target};
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL alias_miss: taken/target=%h required %h", got_v, exp_v);
    end
    look(32'h60);
    exp_v = sb_q.pop_front();
    got_v = {31'd0, bus.pred_taken, bus.pred_target};
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL alias_orig: taken/target=%h required %h", got_v, exp_v);
    end
    train(32'h160, 1'b1, 32'h300);
    sb_q.push_back({31'd0, 1'b1, 32'h300});
    sb_q.push_back({31'd0, 1'b0, 32'h64});
    look(32'h160);
    exp_v = sb_q.pop_front();
    got_v = {31'd0, bus.pred_taken, bus.pred_target};
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL alias_over: taken/target=%h required %h", got_v, exp_v);
    end
    look(32'h60);
    exp_v = sb_q.pop_front();
    got_v = {31'd0, bus.pred_taken, bus.pred_target};
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL alias_evict: taken/target=%h required %h", got_v, exp_v);
    end
  endtask

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  task automatic test_gshare();
    logic [5:0] bits;
    do_reset();
    wait_ready();
    train(32'h80, 1'b1, 32'h90);
    train(32'h60, 1'b1, 32'h40);
    sb_q.push_back({25'd0, 1'b0, 6'h1B, 32'h40});
    look(32'h60);
    exp_v = sb_q.pop_front();
    got_v = {25'd0, bus.pred_taken, bus.pred_idx, bus.pred_target};
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL gshare_h3: taken/idx/target=%h required %h", got_v, exp_v);
    end
    bits = 6'b000001;
    for (int i = 5; i >= 0; i--)
      train(32'h84, bits[i], 32'h94);
    sb_q.push_back({25'd0, 1'b1, 6'h19, 32'h40});
    look(32'h60);
    exp_v = sb_q.pop_front();
    got_v = {25'd0, bus.pred_taken, bus.pred_idx, bus.pred_target};
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL gshare_h1: taken/idx/target=%h required %h", got_v, exp_v);
    end
  endtask
`endif

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.if_pc          = '0;
    bus.ex_valid       = 1'b0;
    bus.ex_pc          = '0;
    bus.ex_idx         = '0;
    bus.ex_br_en       = 1'b0;
    bus.ex_target      = '0;
    bus.ex_pred_taken  = 1'b0;
    bus.ex_pred_target = '0;
    m_ctr              = 2'b01;
    test_reset();
    test_train();
    test_saturation();
    test_hazard();
    test_mispredict();
    test_back_to_back();
    test_reset_mid_init();
    test_alias();
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    test_gshare();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
